// File: rtl/adder_share_arb.sv
// adder_share_arb: arbitrates NREQ requesters onto one shared WIDTH-bit
// ripple-carry adder. Operands are held for SETTLE cycles, then
// {carry, sum} is returned with the owning requester ID.
// Build option: ADDER_SHARE_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) in place of the default round-robin grant.
module adder_share_arb #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [WIDTH:0]            resp_sum
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH:0]   adder_out;

`ifndef ADDER_SHARE_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   cand;

  // Modular (p + off) over NREQ entries; off never exceeds NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p,
                                              input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = wrap_add(ptr_q, off);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`else
  // Fixed priority: lowest-index valid requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_vld && req_valid[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end
`endif

  // One-hot ready only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == ST_IDLE) && gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // Shared adder fed from the held operand registers.
  always_comb begin
    adder_out = {1'b0, a_q} + {1'b0, b_q};
  end

  // Sequencer: accept, hold for the settle window, present the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    sum_d   = sum_q;
`ifndef ADDER_SHARE_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_d = ST_CALC;
          cnt_d   = CW'(SETTLE - 1);
          a_d     = req_a[int'(gnt_idx) * WIDTH +: WIDTH];
          b_d     = req_b[int'(gnt_idx) * WIDTH +: WIDTH];
          id_d    = gnt_idx;
`ifndef ADDER_SHARE_ARB_FIXED_PRIO_EN
          ptr_d   = gnt_idx;
`endif
        end
      end
      ST_CALC: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          sum_d   = adder_out;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      sum_q   <= '0;
`ifndef ADDER_SHARE_ARB_FIXED_PRIO_EN
      ptr_q   <= IDW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
`ifndef ADDER_SHARE_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed self-checking bench for adder_share_arb (NREQ=4, WIDTH=32, SETTLE=2).
module tb_adder_share_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [1:0]   resp_id;
  logic [32:0]  resp_sum;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  adder_share_arb #(.NREQ(4), .WIDTH(32), .SETTLE(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one transaction from IDLE; lat counts cycles from accept edge to resp_valid.
  task automatic do_op(input int unsigned idx, input logic [31:0] a, input logic [31:0] b,
                       output logic [3:0] rdy, output int lat, output logic [32:0] sum,
                       output logic [1:0] id, output logic vld_after);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    #1;
    rdy = req_ready;
    sum = 'x;
    id  = 'x;
    vld_after = 1'bx;
    if (req_ready[idx] !== 1'b1) begin
      lat = -1;
      req_valid = '0;
      return;
    end
    tick();
    req_valid = '0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    sum = resp_sum;
    id  = resp_id;
    tick();
    vld_after = resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_a = {4{32'hDEAD_BEEF}};
    req_b = {4{32'h1234_5678}};
    req_valid = 4'b1111;
    tick();
    tick();
    nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready: got %b expected %b", req_ready, 4'b0000); end
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    nvec++; if (resp_id !== 2'd0) begin nerr++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
    nvec++; if (resp_sum !== 33'h0) begin nerr++; $display("FAIL reset_resp_sum: got %h expected %h", resp_sum, 33'h0); end
    rst = 1'b0;
    req_valid = 4'b0001;
    #1;
    nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL reset_first_grant: got %b expected %b", req_ready, 4'b0001); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    logic [3:0] rdy; int lat; logic [32:0] sum; logic [1:0] id; logic va;
    apply_reset();
    do_op(0, 32'h0000_0003, 32'h0000_0004, rdy, lat, sum, id, va);
    nvec++; if (rdy !== 4'b0001) begin nerr++; $display("FAIL single_ready: got %b expected %b", rdy, 4'b0001); end
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL single_latency: got %0d expected 3", lat); end
    nvec++; if (sum !== 33'h0_0000_0007) begin nerr++; $display("FAIL single_sum: got %h expected %h", sum, 33'h0_0000_0007); end
    nvec++; if (id !== 2'd0) begin nerr++; $display("FAIL single_id: got %0d expected 0", id); end
    nvec++; if (va !== 1'b0) begin nerr++; $display("FAIL single_one_cycle_valid: got %b expected 0", va); end
  endtask

  task automatic test_carry();
    logic [3:0] rdy; int lat; logic [32:0] sum; logic [1:0] id; logic va;
    do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, rdy, lat, sum, id, va);
    nvec++; if (sum !== 33'h1_0000_0000) begin nerr++; $display("FAIL carry_wrap: got %h expected %h", sum, 33'h1_0000_0000); end
    do_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rdy, lat, sum, id, va);
    nvec++; if (sum !== 33'h1_FFFF_FFFE) begin nerr++; $display("FAIL carry_max: got %h expected %h", sum, 33'h1_FFFF_FFFE); end
    nvec++; if (id !== 2'd2) begin nerr++; $display("FAIL carry_max_id: got %0d expected 2", id); end
    do_op(1, 32'h7FFF_FFFF, 32'h0000_0001, rdy, lat, sum, id, va);
    nvec++; if (sum !== 33'h0_8000_0000) begin nerr++; $display("FAIL carry_none: got %h expected %h", sum, 33'h0_8000_0000); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy [5];
    logic [32:0] exp_sum [5];
    logic [3:0]  g_rdy [5];
    int          g_cyc [5];
    logic [32:0] r_sum [5];
    logic [1:0]  r_id  [5];
    logic [1:0]  exp_id [5];
    int ng, nr;
`ifdef ADDER_SHARE_ARB_FIXED_PRIO_EN
    exp_rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_id  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    exp_sum = '{33'h1_0000_0000, 33'h1_0000_0000, 33'h1_0000_0000, 33'h1_0000_0000, 33'h1_0000_0000};
`else
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_sum = '{33'h1_0000_0000, 33'h1_0000_0011, 33'h1_0000_0022, 33'h1_0000_0033, 33'h1_0000_0000};
`endif
    apply_reset();
    req_a = {32'h8000_0003, 32'h8000_0002, 32'h8000_0001, 32'h8000_0000};
    req_b = {32'h8000_0030, 32'h8000_0020, 32'h8000_0010, 32'h8000_0000};
    req_valid = 4'b1111;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready !== 4'b0000 && ng < 5) begin g_rdy[ng] = req_ready; g_cyc[ng] = c; ng++; end
      if (resp_valid === 1'b1 && nr < 5) begin r_sum[nr] = resp_sum; r_id[nr] = resp_id; nr++; end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    nvec++; if (ng !== 5) begin nerr++; $display("FAIL rr_grant_count: got %0d expected 5", ng); end
    nvec++; if (nr !== 5) begin nerr++; $display("FAIL rr_resp_count: got %0d expected 5", nr); end
    for (int k = 0; k < 5; k++) begin
      if (k < ng) begin
        nvec++; if (g_rdy[k] !== exp_rdy[k]) begin nerr++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, g_rdy[k], exp_rdy[k]); end
        nvec++; if (g_cyc[k] !== 4 * k) begin nerr++; $display("FAIL rr_grant_cycle[%0d]: got %0d expected %0d", k, g_cyc[k], 4 * k); end
      end
      if (k < nr) begin
        nvec++; if (r_id[k] !== exp_id[k]) begin nerr++; $display("FAIL rr_resp_id[%0d]: got %0d expected %0d", k, r_id[k], exp_id[k]); end
        nvec++; if (r_sum[k] !== exp_sum[k]) begin nerr++; $display("FAIL rr_resp_sum[%0d]: got %h expected %h", k, r_sum[k], exp_sum[k]); end
      end
    end
    apply_reset();
  endtask

  task automatic test_backpressure();
    int w;
    apply_reset();
    resp_ready = 1'b0;
    req_a[32 +: 32] = 32'h1234_5678;
    req_b[32 +: 32] = 32'h1111_1111;
    req_valid = 4'b0010;
    #1;
    nvec++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL bp_grant: got %b expected %b", req_ready, 4'b0010); end
    tick();
    req_valid = 4'b0101;
    w = 0;
    while (resp_valid !== 1'b1 && w < 20) begin tick(); w++; end
    nvec++; if (resp_valid !== 1'b1) begin nerr++; $display("FAIL bp_resp_timeout: got %b expected 1", resp_valid); end
    for (int k = 0; k < 5; k++) begin
      nvec++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 33'h0_2345_6789 || req_ready !== 4'b0000) begin
        nerr++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h rdy=%b expected v=1 id=1 sum=%h rdy=0000",
                 k, resp_valid, resp_id, resp_sum, req_ready, 33'h0_2345_6789);
      end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    nvec++; if (resp_valid !== 1'b1) begin nerr++; $display("FAIL bp_release_valid: got %b expected 1", resp_valid); end
    tick();
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL bp_complete: got %b expected 0", resp_valid); end
`ifdef ADDER_SHARE_ARB_FIXED_PRIO_EN
    nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL bp_back_to_back: got %b expected %b", req_ready, 4'b0001); end
`else
    nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL bp_back_to_back: got %b expected %b", req_ready, 4'b0100); end
`endif
    apply_reset();
  endtask

  task automatic test_reset_mid_op();
    int seen;
    apply_reset();
    req_a[64 +: 32] = 32'h0000_0100;
    req_b[64 +: 32] = 32'h0000_0200;
    req_valid = 4'b0100;
    #1;
    nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL rmid_grant: got %b expected %b", req_ready, 4'b0100); end
    tick();
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL rmid_ready_in_reset: got %b expected 0000", req_ready); end
    tick();
    nvec++;
    if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_sum !== 33'h0 || req_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL rmid_outputs_in_reset: got v=%b id=%0d sum=%h rdy=%b expected all 0", resp_valid, resp_id, resp_sum, req_ready);
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid !== 1'b0) seen++;
      tick();
    end
    nvec++; if (seen !== 0) begin nerr++; $display("FAIL rmid_no_response: got %0d valid cycles expected 0", seen); end
    req_valid = 4'b1111;
    #1;
    nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL rmid_next_grant: got %b expected %b", req_ready, 4'b0001); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_skip_idle();
    logic [3:0] rdy; int lat; logic [32:0] sum; logic [1:0] id; logic va;
    int w;
    apply_reset();
    do_op(0, 32'h0000_0001, 32'h0000_0001, rdy, lat, sum, id, va);
    req_a[96 +: 32] = 32'h0000_0005;
    req_b[96 +: 32] = 32'h0000_0006;
    req_valid = 4'b1000;
    #1;
    nvec++; if (req_ready !== 4'b1000) begin nerr++; $display("FAIL skip_grant: got %b expected %b", req_ready, 4'b1000); end
    tick();
    req_valid = '0;
    w = 0;
    while (resp_valid !== 1'b1 && w < 20) begin tick(); w++; end
    nvec++; if (resp_id !== 2'd3 || resp_sum !== 33'h0_0000_000B) begin
      nerr++; $display("FAIL skip_resp: got id=%0d sum=%h expected id=3 sum=%h", resp_id, resp_sum, 33'h0_0000_000B);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_skip_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Arbiter and sequencer that shares one 32-bit ripple-carry adder datapath between several requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers its operands, and holds them stable for a fixed settle window while the ripple chain resolves. It then returns the 33-bit result (carry in the MSB), tagged with the requester ID. It sits between the client blocks and the shared adder instance.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `WIDTH`, 32, operand width.
- `SETTLE`, 2, cycles operands are held before the result is sampled (>=1).

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_a`  in  NREQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same packing.
- `resp_valid`  out  1  result valid.
- `resp_ready`  in  1  consumer accepts result.
- `resp_id`  out  clog2(NREQ)  index of requester that owns the result.
- `resp_sum`  out  WIDTH+1  {carry_out, sum}.

## Operation
- Three states:
  - IDLE: `req_ready` is the one-hot grant over `req_valid`; zero if no request.
  - CALC: operands are held in registers and drive the adder; a down-counter loads SETTLE-1 on entry.
  - RESP: `resp_valid`=1.
- Transitions:
  - IDLE->CALC on any `req_valid[g] & req_ready[g]`. That edge captures `req_a`/`req_b` slice g, and g into the ID register.
  - CALC->RESP when the counter reaches 0. That edge registers the adder output into `resp_sum`.
  - RESP->IDLE on `resp_valid & resp_ready`.
- Arithmetic: `resp_sum` = a + b with carry-in 0, full WIDTH+1 result. There is no truncation or saturation.
- Grant (default round-robin):
  - A last-grant pointer updates on every accept.
  - The search starts at pointer+1 and wraps NREQ-1 -> 0.
  - The pointer resets to NREQ-1, so requester 0 wins first.
- `req_ready` is 0 in CALC and RESP. Requesters must hold valid and operands stable until accepted.
- `resp_id`/`resp_sum` remain stable while `resp_valid`=1 and `resp_ready`=0.
- Reset values:
  - `req_ready`=0 (forced while `rst`=1).
  - `resp_valid`=0, `resp_id`=0, `resp_sum`=0.
  - State IDLE, pointer NREQ-1, counter 0.
- Reset mid-operation: the transaction in flight is discarded and no response is produced. The first accept is possible in the first cycle with `rst`=0.
- A deasserted `req_valid` is never granted. Changing `req_valid` while in CALC/RESP has no effect.

## Timing
- Accept edge = T. CALC occupies cycles T+1..T+SETTLE. `resp_valid` rises in cycle T+SETTLE+1.
- With `resp_ready` held high, `resp_valid` is high for exactly one cycle. IDLE is re-entered in cycle T+SETTLE+2.
- Minimum issue interval is SETTLE+2 cycles; default 4.
- `req_ready` is combinational from `req_valid`, state and pointer. There is no combinational path from `resp_ready` to `req_ready`.
- Back-to-back: a request pending during RESP is accepted in the first IDLE cycle.

## Configuration
- `ADDER_SHARE_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority; the lowest-index valid requester always wins, and the pointer logic is removed.
  - Undefined (default): round-robin as above.

## Test plan
- Single request: after reset, req0 a=0x0000_0003, b=0x0000_0004 -> `req_ready`=4'b0001 same cycle; `resp_valid` 3 cycles after accept; `resp_sum`=0x0_0000_0007, `resp_id`=0.
- Carry/wrap: a=0xFFFF_FFFF, b=0x0000_0001 -> `resp_sum`=0x1_0000_0000. Also a=b=0xFFFF_FFFF -> 0x1_FFFF_FFFE.
- Round-robin: all four valid continuously, `resp_ready`=1 -> grant order 0,1,2,3,0, one accept every 4 cycles. With `ADDER_SHARE_ARB_FIXED_PRIO_EN` defined -> always 0.
- Backpressure: `resp_ready`=0 for 5 cycles -> `resp_valid`, `resp_id`, `resp_sum` held constant and `req_ready`=0 throughout; the response completes on the cycle `resp_ready` rises.
- Reset mid-op: accept req2, assert `rst` in the first CALC cycle -> no `resp_valid`. All outputs read 0 during reset, and the next grant goes to req0.
- Skip idle: only req3 valid with pointer=0 -> req3 granted immediately, with no empty grant cycles.
